// File: rtl/alu_issue_stage_if.sv
// Bundle of all issue-stage signals between register read, the issue stage
// and the ALU. The slave modport is the issue stage's view; the master
// modport is the surrounding pipeline's (or a bench's) view.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            ex_we_i;
  logic [4:0]      ex_rd_i;
  logic [XLEN-1:0] ex_data_i;
  logic            wb_we_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [3:0]      ALUCtl_o;
  logic [XLEN-1:0] Op1_o;
  logic [XLEN-1:0] Op2_o;
  logic [4:0]      rd_o;
  logic            reg_write_o;
  logic            illegal_o;

  modport slave (
    input  flush_i, in_valid_i, instr_i, rs1_data_i, rs2_data_i,
    input  ex_we_i, ex_rd_i, ex_data_i, wb_we_i, wb_rd_i, wb_data_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, ALUCtl_o, Op1_o, Op2_o, rd_o,
    output reg_write_o, illegal_o
  );

  modport master (
    output flush_i, in_valid_i, instr_i, rs1_data_i, rs2_data_i,
    output ex_we_i, ex_rd_i, ex_data_i, wb_we_i, wb_rd_i, wb_data_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, ALUCtl_o, Op1_o, Op2_o, rd_o,
    input  reg_write_o, illegal_o
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the RV32I integer ALU: decodes R/I arithmetic and
// logic instructions into ALU control codes, resolves Op1/Op2 with EX>WB
// forwarding, and registers the result behind a valid/ready boundary.
//
// Handshake: an instruction enters when in_valid_i && in_ready_o, with
// in_ready_o = !out_valid_o || out_ready_i; it leaves when
// out_valid_o && out_ready_i. While out_valid_o=1 and out_ready_i=0 every
// output holds. flush_i on an edge drops the held and the incoming
// instruction and wins over a simultaneous transfer.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_issue_stage_if.slave   bus
);

  localparam logic [3:0] ALU_CTL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTL_XOR = 4'b0011;
  localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTL_SLT = 4'b0111;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm;
  logic            w_f3_ok;
  logic [3:0]      w_f3_ctl;
  logic            w_legal;
  logic [3:0]      w_ctl;
  logic            w_is_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op2;
  logic            w_in_ready;
  logic            w_fire;

  logic            r_out_valid;
  logic [3:0]      r_alu_ctl;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_illegal;

  assign w_opcode = bus.instr_i[6:0];
  assign w_rd     = bus.instr_i[11:7];
  assign w_funct3 = bus.instr_i[14:12];
  assign w_rs1    = bus.instr_i[19:15];
  assign w_rs2    = bus.instr_i[24:20];
  assign w_funct7 = bus.instr_i[31:25];
  assign w_imm    = {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:20]};

  assign w_in_ready = !r_out_valid || bus.out_ready_i;
  assign w_fire     = bus.in_valid_i && w_in_ready;

  // funct3 table shared by R (funct7=0) and I forms; shifts and SLTU are absent
  always_comb begin
    w_f3_ok  = 1'b1;
    w_f3_ctl = ALU_CTL_ADD;
    case (w_funct3)
      3'b000:  w_f3_ctl = ALU_CTL_ADD;
      3'b010:  w_f3_ctl = ALU_CTL_SLT;
      3'b100:  w_f3_ctl = ALU_CTL_XOR;
      3'b110:  w_f3_ctl = ALU_CTL_OR;
      3'b111:  w_f3_ctl = ALU_CTL_AND;
      default: w_f3_ok  = 1'b0;
    endcase
  end

  // opcode/funct7 qualification of the funct3 table, plus the SUB special case
  always_comb begin
    w_legal  = 1'b0;
    w_ctl    = ALU_CTL_ADD;
    w_is_imm = 1'b0;
    if (w_opcode == OPC_R) begin
      if (w_funct7 == 7'b0000000) begin
        w_legal = w_f3_ok;
        w_ctl   = w_f3_ctl;
      end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
        w_legal = 1'b1;
        w_ctl   = ALU_CTL_SUB;
      end
    end else if (w_opcode == OPC_I) begin
      w_is_imm = 1'b1;
      w_legal  = w_f3_ok;
      w_ctl    = w_f3_ctl;
    end
  end

  // rs1 operand: x0 reads zero, then EX result, then WB result, then regfile
  always_comb begin
    w_rs1_val = bus.rs1_data_i;
    if (w_rs1 == 5'd0)
      w_rs1_val = '0;
    else if (bus.ex_we_i && bus.ex_rd_i == w_rs1)
      w_rs1_val = bus.ex_data_i;
    else if (bus.wb_we_i && bus.wb_rd_i == w_rs1)
      w_rs1_val = bus.wb_data_i;
  end

  // rs2 operand with the same priority; only used by R-type
  always_comb begin
    w_rs2_val = bus.rs2_data_i;
    if (w_rs2 == 5'd0)
      w_rs2_val = '0;
    else if (bus.ex_we_i && bus.ex_rd_i == w_rs2)
      w_rs2_val = bus.ex_data_i;
    else if (bus.wb_we_i && bus.wb_rd_i == w_rs2)
      w_rs2_val = bus.wb_data_i;
  end

  assign w_op2 = w_is_imm ? w_imm : w_rs2_val;

  // ID/EX pipeline register: flush beats capture, illegal words only pulse illegal
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_alu_ctl   <= ALU_CTL_ADD;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rd        <= 5'd0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if (bus.flush_i) begin
        r_out_valid <= 1'b0;
      end else if (w_fire) begin
        if (w_legal) begin
          r_out_valid <= 1'b1;
          r_alu_ctl   <= w_ctl;
          r_op1       <= w_rs1_val;
          r_op2       <= w_op2;
          r_rd        <= w_rd;
          r_reg_write <= (w_rd != 5'd0);
        end else begin
          r_out_valid <= 1'b0;
          r_illegal   <= 1'b1;
        end
      end else if (bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.ALUCtl_o    = r_alu_ctl;
  assign bus.Op1_o       = r_op1;
  assign bus.Op2_o       = r_op2;
  assign bus.rd_o        = r_rd;
  assign bus.reg_write_o = r_reg_write;
  assign bus.illegal_o   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized run checked
// against a mnemonic-level reference model and an expected-output queue.
module tb_alu_issue_stage;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_XOR = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [73:0] exp_q[$];

  // ---------------- reference model ----------------
  // Mnemonic-level decode: which ALU op an instruction word means, if any.
  function automatic void ref_decode(input logic [31:0] ins, output bit legal,
                                     output logic [3:0] ctl, output bit uses_imm);
    logic [3:0] by_f3 [8];
    bit         ok_f3 [8];
    int         f3;
    by_f3 = '{C_ADD, C_ADD, C_SLT, C_ADD, C_XOR, C_ADD, C_OR, C_AND};
    ok_f3 = '{1, 0, 1, 0, 1, 0, 1, 1};
    f3 = int'(ins[14:12]);
    legal = 0; ctl = C_ADD; uses_imm = 0;
    if (ins[6:0] == 7'h33 && ins[31:25] == 7'h00) begin
      legal = ok_f3[f3]; ctl = by_f3[f3];
    end else if (ins[6:0] == 7'h33 && ins[31:25] == 7'h20 && f3 == 0) begin
      legal = 1; ctl = C_SUB;
    end else if (ins[6:0] == 7'h13) begin
      legal = ok_f3[f3]; ctl = by_f3[f3]; uses_imm = 1;
    end
  endfunction

  function automatic logic [31:0] ref_src(input int idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (bus.ex_we_i && int'(bus.ex_rd_i) == idx) return bus.ex_data_i;
    if (bus.wb_we_i && int'(bus.wb_rd_i) == idx) return bus.wb_data_i;
    return rf;
  endfunction

  function automatic logic [73:0] ref_out(input logic [31:0] ins);
    bit legal, uses_imm;
    logic [3:0] ctl;
    logic [31:0] op1, op2;
    int imm;
    ref_decode(ins, legal, ctl, uses_imm);
    op1 = ref_src(int'(ins[19:15]), bus.rs1_data_i);
    imm = int'($signed(ins[31:20]));
    op2 = uses_imm ? 32'(imm) : ref_src(int'(ins[24:20]), bus.rs2_data_i);
    return {ctl, op1, op2, ins[11:7], ins[11:7] != 5'd0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_i = 0; bus.in_valid_i = 0; bus.instr_i = 32'h0;
    bus.rs1_data_i = 0; bus.rs2_data_i = 0;
    bus.ex_we_i = 0; bus.ex_rd_i = 0; bus.ex_data_i = 0;
    bus.wb_we_i = 0; bus.wb_rd_i = 0; bus.wb_data_i = 0;
    bus.out_ready_i = 1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid_i = 1; bus.instr_i = ins; bus.rs1_data_i = a; bus.rs2_data_i = b;
  endtask

  function automatic logic [74:0] obs_all();
    return {bus.out_valid_o, bus.ALUCtl_o, bus.Op1_o, bus.Op2_o, bus.rd_o, bus.reg_write_o};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [75:0] rv;
    rv = {1'b0, C_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
    idle_inputs();
    rst = 1;
    #12;
    n_checks++;
    if ({obs_all(), bus.illegal_o} !== rv) begin
      n_fail++; $display("FAIL reset_values got=%h want=%h", {obs_all(), bus.illegal_o}, rv);
    end
    @(negedge clk) rst = 0;
    // hold an instruction under stall, then reset between edges
    issue(32'h40B50533, 32'd7, 32'd9);
    bus.out_ready_i = 0;
    tick();
    bus.in_valid_i = 0;
    n_checks++;
    if (bus.out_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_preload_valid got=%b want=1", bus.out_valid_o);
    end
    tick();
    #2 rst = 1;
    #1;
    n_checks++;
    if ({obs_all(), bus.illegal_o} !== rv) begin
      n_fail++; $display("FAIL reset_mid_stall got=%h want=%h", {obs_all(), bus.illegal_o}, rv);
    end
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready_o);
    end
    @(negedge clk) rst = 0;
    idle_inputs();
  endtask

  task automatic test_sub();
    logic [74:0] want;
    want = {1'b1, C_SUB, 32'd7, 32'd9, 5'd10, 1'b1};
    issue(32'h40B50533, 32'd7, 32'd9);
    tick();
    n_checks++;
    if (obs_all() !== want) begin
      n_fail++; $display("FAIL sub_decode got=%h want=%h", obs_all(), want);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_slti_fwd();
    logic [74:0] want;
    issue(32'hFFF52513, 32'h1234, 32'h4321);
    bus.ex_we_i = 1; bus.ex_rd_i = 10; bus.ex_data_i = 32'h55;
    bus.wb_we_i = 1; bus.wb_rd_i = 10; bus.wb_data_i = 32'h66;
    tick();
    want = {1'b1, C_SLT, 32'h55, 32'hFFFFFFFF, 5'd10, 1'b1};
    n_checks++;
    if (obs_all() !== want) begin
      n_fail++; $display("FAIL slti_ex_fwd got=%h want=%h", obs_all(), want);
    end
    bus.ex_rd_i = 9;
    tick();
    want = {1'b1, C_SLT, 32'h66, 32'hFFFFFFFF, 5'd10, 1'b1};
    n_checks++;
    if (obs_all() !== want) begin
      n_fail++; $display("FAIL slti_wb_fwd got=%h want=%h", obs_all(), want);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [74:0] w1, w2;
    w1 = {1'b1, C_ADD, 32'd0, 32'd0, 5'd1, 1'b1};
    w2 = {1'b1, C_OR, 32'h33, 32'h44, 5'd2, 1'b1};
    issue(32'h000000B3, 32'hAA, 32'hBB);
    bus.out_ready_i = 0;
    tick();
    issue(32'h0041E133, 32'h33, 32'h44);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_all() !== w1 || bus.in_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL b2b_hold%0d got=%h rdy=%b want=%h rdy=0", i, obs_all(), bus.in_ready_o, w1);
      end
      tick();
    end
    bus.out_ready_i = 1;
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready got=%b want=1", bus.in_ready_o);
    end
    tick();
    bus.in_valid_i = 0;
    n_checks++;
    if (obs_all() !== w2) begin
      n_fail++; $display("FAIL b2b_second got=%h want=%h", obs_all(), w2);
    end
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain got=%b want=0", bus.out_valid_o);
    end
    idle_inputs();
  endtask

  task automatic test_illegal();
    logic [31:0] bad [4];
    bad = '{32'h00B51533, 32'h00B53533, 32'h00153513, 32'h00000037};
    for (int i = 0; i < 4; i++) begin
      issue(bad[i], 32'd1, 32'd2);
      tick();
      bus.in_valid_i = 0;
      n_checks++;
      if (bus.out_valid_o !== 1'b0 || bus.illegal_o !== 1'b1) begin
        n_fail++; $display("FAIL illegal%0d_pulse got v=%b ill=%b want v=0 ill=1", i, bus.out_valid_o, bus.illegal_o);
      end
      tick();
      n_checks++;
      if (bus.illegal_o !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d_clear got=%b want=0", i, bus.illegal_o);
      end
    end
    idle_inputs();
  endtask

  task automatic test_x0_dest();
    logic [74:0] want;
    want = {1'b1, C_ADD, 32'd3, 32'd4, 5'd0, 1'b0};
    issue(32'h00208033, 32'd3, 32'd4);
    tick();
    n_checks++;
    if (obs_all() !== want) begin
      n_fail++; $display("FAIL x0_dest got=%h want=%h", obs_all(), want);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    issue(32'h000000B3, 32'd0, 32'd0);
    bus.out_ready_i = 0;
    tick();
    issue(32'h0041E133, 32'd5, 32'd6);
    bus.out_ready_i = 1;
    bus.flush_i = 1;
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_legal got v=%b ill=%b want 0 0", bus.out_valid_o, bus.illegal_o);
    end
    issue(32'h00B51533, 32'd5, 32'd6);
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_illegal got v=%b ill=%b want 0 0", bus.out_valid_o, bus.illegal_o);
    end
    idle_inputs();
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0] good_f3 [5];
    logic [2:0] bad_f3 [3];
    logic [31:0] rd, rs1, rs2;
    good_f3 = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
    bad_f3  = '{3'd1, 3'd3, 3'd5};
    rd  = $urandom_range(0, 7);
    rs1 = $urandom_range(0, 7);
    rs2 = $urandom_range(0, 7);
    case ($urandom_range(0, 5))
      0: return (rs2 << 20) | (rs1 << 15) | (32'(good_f3[$urandom_range(0, 4)]) << 12) | (rd << 7) | 32'h33;
      1: return 32'h40000000 | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
      2: return ($urandom_range(0, 4095) << 20) | (rs1 << 15) | (32'(good_f3[$urandom_range(0, 4)]) << 12) | (rd << 7) | 32'h13;
      3: return (rs2 << 20) | (rs1 << 15) | (32'(bad_f3[$urandom_range(0, 2)]) << 12) | (rd << 7) |
                ($urandom_range(0, 1) ? 32'h33 : 32'h13);
      4: return $urandom();
      default: return ($urandom_range(1, 127) << 25) | (rs2 << 20) | (rs1 << 15) | ($urandom_range(0, 7) << 12) | (rd << 7) | 32'h33;
    endcase
  endfunction

  task automatic test_random();
    bit m_valid, m_ill, m_ready, legal, uses_imm;
    logic [3:0] ctl;
    logic [73:0] exp_v, got_v;
    idle_inputs();
    tick();
    m_valid = 0; m_ill = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_valid_i  = ($urandom_range(0, 3) != 0);
      bus.out_ready_i = ($urandom_range(0, 2) != 0);
      bus.flush_i     = ($urandom_range(0, 9) == 0);
      bus.instr_i     = rand_instr();
      bus.rs1_data_i  = $urandom();
      bus.rs2_data_i  = $urandom();
      bus.ex_we_i = $urandom_range(0, 1); bus.ex_rd_i = 5'($urandom_range(0, 7)); bus.ex_data_i = $urandom();
      bus.wb_we_i = $urandom_range(0, 1); bus.wb_rd_i = 5'($urandom_range(0, 7)); bus.wb_data_i = $urandom();
      #1;
      m_ready = !m_valid || bus.out_ready_i;
      n_checks++;
      if (bus.in_ready_o !== m_ready) begin
        n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready_o, m_ready);
      end
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i) begin
        got_v = {bus.ALUCtl_o, bus.Op1_o, bus.Op2_o, bus.rd_o, bus.reg_write_o};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra_out cyc=%0d got=%h want=none", cyc, got_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v) begin
            n_fail++; $display("FAIL rand_out cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
          end
        end
      end
      if (bus.flush_i) begin
        m_valid = 0; m_ill = 0;
        exp_q.delete();
      end else if (bus.in_valid_i && m_ready) begin
        ref_decode(bus.instr_i, legal, ctl, uses_imm);
        m_valid = legal; m_ill = !legal;
        if (legal) exp_q.push_back(ref_out(bus.instr_i));
      end else begin
        if (bus.out_ready_i) m_valid = 0;
        m_ill = 0;
      end
      tick();
      n_checks++;
      if (bus.out_valid_o !== m_valid || bus.illegal_o !== m_ill) begin
        n_fail++; $display("FAIL rand_state cyc=%0d got v=%b ill=%b want v=%b ill=%b",
                           cyc, bus.out_valid_o, bus.illegal_o, m_valid, m_ill);
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sub();
    test_slti_fwd();
    test_back_to_back();
    test_illegal();
    test_x0_dest();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
